inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction-fetch responder for the PC generator. It captures the fetch address when `ce_i` is high and runs one instruction-memory read at a time over a req/gnt/rvalid bus. It returns the instruction with its address to the IF/ID stage, and raises `stallreq_o` so the PC holds until the fetch completes. On a branch it squashes the in-flight fetch and drops the stale response.

## Interface
- `NOP_INST`, default `32'h0000_0013`: instruction substituted when a fetch returns an error.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset (`RstEnable` = 0).
- `pc_i`  in  32  fetch address from the PC generator (`InstAddrBus`).
- `ce_i`  in  1  fetch enable from the PC generator (`ce_o`).
- `branch_flag_i`  in  1  branch/redirect taken this cycle; flushes the fetch.
- `stalled`  in  6  pipeline stall vector; bit 1 = IF/ID hold (`Stop`).
- `mem_req_o`  out  1  read request to instruction memory.
- `mem_addr_o`  out  32  read address; stable while `mem_req_o`=1.
- `mem_gnt_i`  in  1  request accepted this cycle.
- `mem_rvalid_i`  in  1  read data valid.
- `mem_rdata_i`  in  32  read data.
- `mem_err_i`  in  1  bus error; qualified by `mem_rvalid_i`.
- `inst_o`  out  32  fetched instruction (`RegBus`).
- `inst_addr_o`  out  32  address of `inst_o`.
- `inst_valid_o`  out  1  `inst_o`/`inst_addr_o` valid.
- `fetch_err_o`  out  1  one-cycle pulse when `inst_o` was substituted because of an error.
- `stallreq_o`  out  1  request to hold the PC (combinational).

## Operation
- FSM states:
  - IDLE: no request.
  - REQ: `mem_req_o`=1, `mem_addr_o`=addr_q.
  - RESP: granted, waiting for `rvalid`.
  - DROP: granted, but a branch squashed the fetch; the response is discarded.
- IDLE → REQ when `ce_i`=1, `branch_flag_i`=0 and not (`inst_valid_o`=1 and `stalled[1]`=Stop). The same edge captures `pc_i` into addr_q.
- REQ:
  - `gnt` with no branch → RESP.
  - branch with no `gnt` → IDLE (request withdrawn).
  - branch with `gnt` → DROP.
  - neither → stay in REQ.
- RESP:
  - `rvalid` with no branch → IDLE. The same edge loads `inst_o`←rdata (or `NOP_INST` if `mem_err_i`), `inst_addr_o`←addr_q, `inst_valid_o`←1, and `fetch_err_o`←`mem_err_i`.
  - `rvalid` with branch → IDLE; the data is discarded.
  - branch with no `rvalid` → DROP.
- DROP: `rvalid` → IDLE (data discarded). Branches in DROP are ignored.
- `mem_rvalid_i` in IDLE or REQ is ignored (protocol violation, no effect).
- `inst_valid_o`:
  - cleared on any cycle with `branch_flag_i`=1;
  - otherwise cleared one cycle after being set unless `stalled[1]`=Stop, in which case `inst_o`, `inst_addr_o` and `inst_valid_o` all hold.
- `stallreq_o` =
  - 1 in DROP;
  - 0 when `branch_flag_i`=1 in any other state;
  - otherwise `ce_i` AND NOT (state==RESP AND `mem_rvalid_i`).
- Net effect: the PC advances exactly in the response cycle.
- Reset: state IDLE; `mem_req_o`=0, `mem_addr_o`=0, `inst_o`=0, `inst_addr_o`=0, `inst_valid_o`=0, `fetch_err_o`=0. A response that arrives after reset is ignored.

## Timing
- At most one outstanding transaction. A new request is never issued before the previous response, or the dropped response, has returned.
- With zero-wait memory (gnt in the first REQ cycle, rvalid in the cycle after gnt):
  - cycle 0: IDLE, address captured;
  - cycle 1: REQ+gnt;
  - cycle 2: RESP+rvalid;
  - cycle 3: `inst_valid_o`=1.
  - Throughput is 1 instruction per 3 cycles.
- `mem_addr_o` and `mem_req_o` come from flops and state only. There is no combinational path from `pc_i` to the bus.
- `stallreq_o` is combinational from `ce_i`, `branch_flag_i`, `mem_rvalid_i` and state.
- `fetch_err_o` pulses for exactly one cycle, aligned with the first cycle of the corresponding `inst_valid_o`.

## Test plan
- Reset then `ce_i`=1, `pc_i`=0x8000_0000, zero-wait memory returning 0x0010_0093 → `mem_addr_o`=0x8000_0000 in cycle 1. Cycle 3: `inst_o`=0x0010_0093, `inst_addr_o`=0x8000_0000, `inst_valid_o`=1. `stallreq_o`=1 in cycles 0–1 and 0 in cycle 2.
- `gnt` delayed 3 cycles and `rvalid` delayed 2 more → `mem_req_o` and `mem_addr_o` held stable throughout, `stallreq_o`=1 until the rvalid cycle, a single `inst_valid_o` pulse.
- Branch in RESP before `rvalid`, then `rvalid` with data 0xDEAD_BEEF → state DROP, `stallreq_o`=1 until the discard. `inst_valid_o` never set for 0xDEAD_BEEF. The next fetch uses the branch address.
- Branch in REQ without `gnt` → `mem_req_o` drops next cycle, no DROP state entered, `stallreq_o`=0 in the branch cycle.
- `mem_err_i`=1 with `rvalid` → `inst_o`=0x0000_0013, `fetch_err_o` pulses one cycle.
- `inst_valid_o`=1 with `stalled[1]`=Stop for 4 cycles → outputs hold and no new request is issued. After release, valid clears and fetching resumes. Asserting `rst`=0 mid-RESP → all outputs 0 immediately.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction-fetch responder: captures the PC, runs one req/gnt/rvalid read at a time,
// hands the instruction to IF/ID and squashes the in-flight fetch on a branch.
module inst_fetch #(
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        ce_i,
    input  logic        branch_flag_i,
    input  logic [5:0]  stalled,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        inst_valid_o,
    output logic        fetch_err_o,
    output logic        stallreq_o
);

    localparam int unsigned XLEN         = 32;
    localparam int unsigned STALL_IF_BIT = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t          state;
    state_t          state_n;

    logic            req_d;
    logic [XLEN-1:0] addr_d;
    logic [XLEN-1:0] inst_d;
    logic [XLEN-1:0] iaddr_d;
    logic            valid_d;
    logic            ferr_d;

    logic            hold_c;
    logic            start_c;
    logic            deliver_c;
    logic            unused_stall;

    // IF/ID holding a valid instruction blocks new fetches and freezes the outputs
    assign hold_c       = inst_valid_o & stalled[STALL_IF_BIT];
    assign start_c      = ce_i & ~branch_flag_i & ~hold_c;
    assign deliver_c    = (state == RESP) & mem_rvalid_i & ~branch_flag_i;
    assign unused_stall = ^{stalled[5:2], stalled[0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (start_c) state_n = REQ;
            end
            REQ: begin
                if (branch_flag_i) state_n = mem_gnt_i ? DROP : IDLE;
                else if (mem_gnt_i) state_n = RESP;
            end
            RESP: begin
                if (mem_rvalid_i) state_n = IDLE;
                else if (branch_flag_i) state_n = DROP;
            end
            DROP: begin
                if (mem_rvalid_i) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Next values of the registered outputs, plus the combinational PC hold request
    always_comb begin
        req_d      = (state_n == REQ);
        addr_d     = mem_addr_o;
        inst_d     = inst_o;
        iaddr_d    = inst_addr_o;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
        stallreq_o = 1'b0;

        if ((state == IDLE) && start_c) addr_d = pc_i;

        if (deliver_c) begin
            inst_d  = mem_err_i ? NOP_INST : mem_rdata_i;
            iaddr_d = mem_addr_o;
            valid_d = 1'b1;
            ferr_d  = mem_err_i;
        end else if (hold_c && !branch_flag_i) begin
            valid_d = 1'b1;
        end

        if (state == DROP) stallreq_o = 1'b1;
        else if (!branch_flag_i) stallreq_o = ce_i & ~((state == RESP) & mem_rvalid_i);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req_o    <= 1'b0;
            mem_addr_o   <= '0;
            inst_o       <= '0;
            inst_addr_o  <= '0;
            inst_valid_o <= 1'b0;
            fetch_err_o  <= 1'b0;
        end else begin
            mem_req_o    <= req_d;
            mem_addr_o   <= addr_d;
            inst_o       <= inst_d;
            inst_addr_o  <= iaddr_d;
            inst_valid_o <= valid_d;
            fetch_err_o  <= ferr_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed vector table, hand-written corner sequences, and a
// randomized run checked against a program-order instruction-stream model.
module tb_inst_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        ce_i;
    logic        branch_flag_i;
    logic [5:0]  stalled;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        mem_err_i;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_valid_o;
    logic        fetch_err_o;
    logic        stallreq_o;

    always #5 clk = ~clk;

    inst_fetch #(.NOP_INST(NOP)) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_i          (pc_i),
        .ce_i          (ce_i),
        .branch_flag_i (branch_flag_i),
        .stalled       (stalled),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i),
        .mem_err_i     (mem_err_i),
        .inst_o        (inst_o),
        .inst_addr_o   (inst_addr_o),
        .inst_valid_o  (inst_valid_o),
        .fetch_err_o   (fetch_err_o),
        .stallreq_o    (stallreq_o)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        ce;
        logic [31:0] pc;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        err;
        logic        br;
        logic        st;
        logic        req;
        logic [31:0] addr;
        logic [31:0] inst;
        logic [31:0] iaddr;
        logic        valid;
        logic        ferr;
        logic        sreq;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic ce, input logic [31:0] pc, input logic gnt, input logic rv,
                                input logic [31:0] rdata, input logic err, input logic br, input logic st,
                                input logic req, input logic [31:0] addr, input logic [31:0] inst,
                                input logic [31:0] iaddr, input logic valid, input logic ferr,
                                input logic sreq);
        vec_t v;
        v = '{ce, pc, gnt, rv, rdata, err, br, st, req, addr, inst, iaddr, valid, ferr, sreq};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input logic ce, input logic [31:0] pc, input logic gnt, input logic rv,
                         input logic [31:0] rd, input logic err, input logic br, input logic st);
        @(posedge clk);
        #1;
        ce_i          = ce;
        pc_i          = pc;
        mem_gnt_i     = gnt;
        mem_rvalid_i  = rv;
        mem_rdata_i   = rd;
        mem_err_i     = err;
        branch_flag_i = br;
        stalled       = {4'b0000, st, 1'b0};
        @(negedge clk);
    endtask

    // Memory contents and error map used by the randomized run
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    function automatic logic mem_bad(input logic [31:0] a);
        return (a[4:2] == 3'd5);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          vcount;
        logic [31:0] pc;
        logic [31:0] exp_addr;
        logic [31:0] out_addr;
        logic [31:0] tgt;
        logic [31:0] del_addr;
        logic [5:0]  sv;
        logic        outstanding;
        logic        prev_valid;
        logic        prev_stall;
        logic        prev_br;
        logic        br;
        logic        st;
        logic        g;
        logic        rv;
        logic        sreq;
        logic        new_del;
        int          dly;
        int          deliveries;

        rst = 1'b0;
        ce_i = 1'b0; pc_i = '0; branch_flag_i = 1'b0; stalled = '0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_err_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req",   32'(mem_req_o), 32'h0);
        chk("rst_addr",  mem_addr_o, 32'h0);
        chk("rst_inst",  inst_o, 32'h0);
        chk("rst_iaddr", inst_addr_o, 32'h0);
        chk("rst_valid", 32'(inst_valid_o), 32'h0);
        chk("rst_ferr",  32'(fetch_err_o), 32'h0);
        rst = 1'b1;

        // ce  pc            gnt rv rdata          err br st | req addr          inst          iaddr         v  fe sq
        vecs.push_back(mk(1, 32'h8000_0000, 0, 0, 32'h0,          0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         0, 0, 1));
        vecs.push_back(mk(1, 32'h8000_0000, 1, 0, 32'h0,          0, 0, 0, 1, 32'h8000_0000, 32'h0,         32'h0,         0, 0, 1));
        vecs.push_back(mk(1, 32'h8000_0000, 0, 1, 32'h0010_0093,  0, 0, 0, 0, 32'h8000_0000, 32'h0,         32'h0,         0, 0, 0));
        vecs.push_back(mk(1, 32'h8000_0004, 0, 0, 32'h0,          0, 0, 0, 0, 32'h8000_0000, 32'h0010_0093, 32'h8000_0000, 1, 0, 1));
        vecs.push_back(mk(1, 32'h8000_0004, 1, 0, 32'h0,          0, 0, 0, 1, 32'h8000_0004, 32'h0010_0093, 32'h8000_0000, 0, 0, 1));
        vecs.push_back(mk(1, 32'h8000_0004, 0, 1, 32'h1234_5678,  1, 0, 0, 0, 32'h8000_0004, 32'h0010_0093, 32'h8000_0000, 0, 0, 0));
        vecs.push_back(mk(1, 32'h8000_0008, 0, 0, 32'h0,          0, 0, 1, 0, 32'h8000_0004, NOP,           32'h8000_0004, 1, 1, 1));
        vecs.push_back(mk(1, 32'h8000_0008, 0, 0, 32'h0,          0, 0, 1, 0, 32'h8000_0004, NOP,           32'h8000_0004, 1, 0, 1));
        vecs.push_back(mk(1, 32'h8000_0008, 0, 0, 32'h0,          0, 0, 1, 0, 32'h8000_0004, NOP,           32'h8000_0004, 1, 0, 1));
        vecs.push_back(mk(1, 32'h8000_0008, 0, 0, 32'h0,          0, 0, 1, 0, 32'h8000_0004, NOP,           32'h8000_0004, 1, 0, 1));
        vecs.push_back(mk(1, 32'h8000_0008, 0, 0, 32'h0,          0, 0, 0, 0, 32'h8000_0004, NOP,           32'h8000_0004, 1, 0, 1));
        vecs.push_back(mk(1, 32'h8000_0008, 0, 0, 32'h0,          0, 1, 0, 1, 32'h8000_0008, NOP,           32'h8000_0004, 0, 0, 0));
        vecs.push_back(mk(1, 32'h9000_0000, 0, 0, 32'h0,          0, 0, 0, 0, 32'h8000_0008, NOP,           32'h8000_0004, 0, 0, 1));
        vecs.push_back(mk(1, 32'h9000_0000, 1, 0, 32'h0,          0, 0, 0, 1, 32'h9000_0000, NOP,           32'h8000_0004, 0, 0, 1));
        vecs.push_back(mk(1, 32'h9000_0000, 0, 0, 32'h0,          0, 1, 0, 0, 32'h9000_0000, NOP,           32'h8000_0004, 0, 0, 0));
        vecs.push_back(mk(1, 32'hA000_0000, 0, 0, 32'h0,          0, 1, 0, 0, 32'h9000_0000, NOP,           32'h8000_0004, 0, 0, 1));
        vecs.push_back(mk(1, 32'hA000_0000, 0, 1, 32'hDEAD_BEEF,  0, 0, 0, 0, 32'h9000_0000, NOP,           32'h8000_0004, 0, 0, 1));
        vecs.push_back(mk(1, 32'hA000_0000, 0, 0, 32'h0,          0, 0, 0, 0, 32'h9000_0000, NOP,           32'h8000_0004, 0, 0, 1));
        vecs.push_back(mk(1, 32'hA000_0000, 1, 0, 32'h0,          0, 0, 0, 1, 32'hA000_0000, NOP,           32'h8000_0004, 0, 0, 1));
        vecs.push_back(mk(1, 32'hA000_0000, 0, 1, 32'h0000_0513,  0, 0, 0, 0, 32'hA000_0000, NOP,           32'h8000_0004, 0, 0, 0));
        vecs.push_back(mk(0, 32'hA000_0004, 0, 0, 32'h0,          0, 0, 0, 0, 32'hA000_0000, 32'h0000_0513, 32'hA000_0000, 1, 0, 0));
        vecs.push_back(mk(0, 32'hA000_0004, 0, 1, 32'hFFFF_FFFF,  1, 0, 0, 0, 32'hA000_0000, 32'h0000_0513, 32'hA000_0000, 0, 0, 0));
        vecs.push_back(mk(0, 32'hA000_0004, 0, 0, 32'h0,          0, 0, 0, 0, 32'hA000_0000, 32'h0000_0513, 32'hA000_0000, 0, 0, 0));

        foreach (vecs[i]) begin
            apply(vecs[i].ce, vecs[i].pc, vecs[i].gnt, vecs[i].rv, vecs[i].rdata,
                  vecs[i].err, vecs[i].br, vecs[i].st);
            chk($sformatf("v%0d_req", i),   32'(mem_req_o),    32'(vecs[i].req));
            chk($sformatf("v%0d_addr", i),  mem_addr_o,        vecs[i].addr);
            chk($sformatf("v%0d_inst", i),  inst_o,            vecs[i].inst);
            chk($sformatf("v%0d_iaddr", i), inst_addr_o,       vecs[i].iaddr);
            chk($sformatf("v%0d_valid", i), 32'(inst_valid_o), 32'(vecs[i].valid));
            chk($sformatf("v%0d_ferr", i),  32'(fetch_err_o),  32'(vecs[i].ferr));
            chk($sformatf("v%0d_sreq", i),  32'(stallreq_o),   32'(vecs[i].sreq));
        end

        // Slow memory: grant after 3 waiting REQ cycles, rvalid 2 cycles after that
        vcount = 0;
        apply(1, 32'hB000_0000, 0, 0, 32'h0, 0, 0, 0);
        chk("dly_idle_sreq", 32'(stallreq_o), 32'h1);
        for (int k = 0; k < 4; k++) begin
            apply(1, 32'hB000_0000, (k == 3), 0, 32'h0, 0, 0, 0);
            if (inst_valid_o) vcount++;
            chk($sformatf("dly_req%0d", k),  32'(mem_req_o), 32'h1);
            chk($sformatf("dly_addr%0d", k), mem_addr_o, 32'hB000_0000);
            chk($sformatf("dly_sreq%0d", k), 32'(stallreq_o), 32'h1);
        end
        for (int k = 0; k < 3; k++) begin
            apply(1, 32'hB000_0000, 0, (k == 2), 32'hC0FF_EE13, 0, 0, 0);
            if (inst_valid_o) vcount++;
            chk($sformatf("dly_resp_req%0d", k), 32'(mem_req_o), 32'h0);
            chk($sformatf("dly_resp_sreq%0d", k), 32'(stallreq_o), (k == 2) ? 32'h0 : 32'h1);
        end
        // Branch together with an IF/ID stall: the branch still clears the valid
        apply(0, 32'hB000_0004, 0, 0, 32'h0, 0, 1, 1);
        if (inst_valid_o) vcount++;
        chk("dly_inst", inst_o, 32'hC0FF_EE13);
        chk("dly_iaddr", inst_addr_o, 32'hB000_0000);
        for (int k = 0; k < 3; k++) begin
            apply(0, 32'hB000_0004, 0, 0, 32'h0, 0, 0, 1);
            if (inst_valid_o) vcount++;
        end
        chk("dly_valid_pulses", 32'(vcount), 32'h1);

        // Reset while waiting for a response
        apply(1, 32'hC000_0000, 0, 0, 32'h0, 0, 0, 0);
        apply(1, 32'hC000_0000, 1, 0, 32'h0, 0, 0, 0);
        @(posedge clk);
        #1;
        mem_gnt_i = 1'b0;
        chk("resp_sreq", 32'(stallreq_o), 32'h1);
        #1;
        rst = 1'b0;
        #1;
        chk("arst_req",   32'(mem_req_o), 32'h0);
        chk("arst_addr",  mem_addr_o, 32'h0);
        chk("arst_inst",  inst_o, 32'h0);
        chk("arst_iaddr", inst_addr_o, 32'h0);
        chk("arst_valid", 32'(inst_valid_o), 32'h0);
        chk("arst_ferr",  32'(fetch_err_o), 32'h0);
        apply(0, 32'hC000_0000, 0, 0, 32'h0, 0, 0, 0);
        rst = 1'b1;
        apply(0, 32'hC000_0000, 0, 1, 32'h1111_1111, 0, 0, 0);
        apply(0, 32'hC000_0000, 0, 0, 32'h0, 0, 0, 0);
        chk("stale_valid", 32'(inst_valid_o), 32'h0);
        chk("stale_inst",  inst_o, 32'h0);
        chk("stale_req",   32'(mem_req_o), 32'h0);

        // Randomized run: delivered instructions must form the program-order stream
        pc = 32'h0000_1000;
        exp_addr = pc;
        outstanding = 1'b0;
        out_addr = '0;
        dly = 0;
        prev_valid = 1'b0;
        prev_stall = 1'b0;
        prev_br = 1'b0;
        deliveries = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            #1;
            br = ($urandom_range(0, 9) == 0);
            tgt = $urandom();
            tgt[1:0] = 2'b00;
            st = ($urandom_range(0, 3) == 0);
            g = mem_req_o && ($urandom_range(0, 1) == 1);
            if (outstanding) rv = (dly == 0);
            else rv = ($urandom_range(0, 15) == 0);
            ce_i = 1'b1;
            pc_i = pc;
            branch_flag_i = br;
            sv = 6'($urandom());
            sv[1] = st;
            stalled = sv;
            mem_gnt_i = g;
            mem_rvalid_i = rv;
            if (rv && outstanding) begin
                mem_rdata_i = mem_word(out_addr);
                mem_err_i = mem_bad(out_addr);
            end else begin
                mem_rdata_i = $urandom();
                mem_err_i = 1'($urandom_range(0, 1));
            end
            @(negedge clk);

            new_del = inst_valid_o && !(prev_valid && prev_stall);
            del_addr = exp_addr;
            if (prev_br) chk("rnd_valid_after_branch", 32'(inst_valid_o), 32'h0);
            if (new_del) begin
                chk("rnd_iaddr", inst_addr_o, exp_addr);
                chk("rnd_inst", inst_o, mem_bad(exp_addr) ? NOP : mem_word(exp_addr));
                exp_addr = exp_addr + 32'd4;
                deliveries++;
            end
            chk("rnd_ferr", 32'(fetch_err_o), 32'(new_del && mem_bad(del_addr)));
            if (mem_req_o) chk("rnd_req_addr", mem_addr_o, exp_addr);
            chk("rnd_one_outstanding", 32'(mem_req_o && outstanding), 32'h0);

            sreq = stallreq_o;
            if (g) begin
                outstanding = 1'b1;
                out_addr = mem_addr_o;
                dly = $urandom_range(0, 2);
            end else if (outstanding) begin
                if (rv) outstanding = 1'b0;
                else dly--;
            end
            if (br) begin
                pc = tgt;
                exp_addr = tgt;
            end else if (!sreq) begin
                pc = pc + 32'd4;
            end
            prev_valid = inst_valid_o;
            prev_stall = st;
            prev_br = br;
        end
        chk("rnd_progress", 32'(deliveries > 50), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
